// File: rtl/alu_cmd_sequencer.sv
// Command-side sequencer for the 4-bit combinational ALU: issues ops, captures ALU flags, returns registered responses.
// Optional feature macro ALU_SEQ_MUL_EN: opcode 6 runs a 4-iteration shift-add multiply through the ALU adder.

module alu_cmd_sequencer (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [2:0] CMD_OP,
    input  logic [3:0] CMD_A,
    input  logic [3:0] CMD_B,
    output logic [3:0] ALU_A,
    output logic [3:0] ALU_B,
    output logic       ALU_AINV,
    output logic       ALU_BNEG,
    output logic [1:0] ALU_OPR,
    input  logic [3:0] ALU_RESULT,
    input  logic       ALU_OVERFLOW,
    input  logic       ALU_ZERO,
    input  logic       ALU_COUT,
    output logic       RSP_VALID,
    input  logic       RSP_READY,
    output logic [7:0] RSP_DATA,
    output logic       RSP_OVERFLOW,
    output logic       RSP_ZERO,
    output logic       RSP_COUT,
    output logic       RSP_ERR,
    output logic [2:0] DBG_STATE
);

    // Handshakes: a transfer happens on a rising edge where VALID && READY.
    // Producers hold VALID and payload stable until that edge; READY/VALID
    // driven by this block are registered and never depend combinationally
    // on the partner's signal.

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_NOR = 3'd5;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [2:0] OP_MUL = 3'd6;
`endif

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_EXEC  = 3'd2,
        S_MUL   = 3'd3,
        S_RESP  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_EXEC  = 3'd2,
        S_RESP  = 3'd4
    } state_t;
`endif

    state_t     state_q, state_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic [2:0] op_q, op_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [3:0] alu_ctl_q, alu_ctl_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_ovf_q, rsp_ovf_d;
    logic       rsp_zero_q, rsp_zero_d;
    logic       rsp_cout_q, rsp_cout_d;
    logic       rsp_err_q, rsp_err_d;
    logic       op_legal;

`ifdef ALU_SEQ_MUL_EN
    logic [8:0] p_q, p_d, p_next;
    logic [1:0] cnt_q, cnt_d;
`endif

    // ALU control word {AINV, BNEG, Opr} for each single-cycle opcode.
    function automatic logic [3:0] op_ctl(input logic [2:0] op);
        logic [3:0] ctl;
        case (op)
            OP_AND:  ctl = 4'b0000;
            OP_OR:   ctl = 4'b0001;
            OP_ADD:  ctl = 4'b0010;
            OP_SUB:  ctl = 4'b0110;
            OP_SLT:  ctl = 4'b0111;
            OP_NOR:  ctl = 4'b1100;
            default: ctl = 4'b0000;
        endcase
        return ctl;
    endfunction

    assign op_legal = (op_q <= OP_NOR);

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctl_d   = alu_ctl_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_err_d   = rsp_err_q;
`ifdef ALU_SEQ_MUL_EN
        p_d         = p_q;
        cnt_d       = cnt_q;
        p_next      = {1'b0, ALU_COUT, ALU_RESULT, p_q[3:1]};
`endif

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (CMD_VALID && cmd_ready_q) begin
                    op_d        = CMD_OP;
                    a_d         = CMD_A;
                    b_d         = CMD_B;
                    cmd_ready_d = 1'b0;
                    state_d     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // Illegal opcodes pass through EXEC with the ALU left idle.
                state_d = S_EXEC;
                if (op_legal) begin
                    alu_a_d   = a_q;
                    alu_b_d   = b_q;
                    alu_ctl_d = op_ctl(op_q);
                end
`ifdef ALU_SEQ_MUL_EN
                else if (op_q == OP_MUL) begin
                    p_d       = {5'b0, a_q};
                    cnt_d     = 2'd0;
                    alu_a_d   = 4'b0;
                    alu_b_d   = a_q[0] ? b_q : 4'b0;
                    alu_ctl_d = op_ctl(OP_ADD);
                    state_d   = S_MUL;
                end
`endif
            end

            S_EXEC: begin
                rsp_valid_d = 1'b1;
                if (op_legal) begin
                    rsp_data_d = {4'b0, ALU_RESULT};
                    rsp_ovf_d  = ALU_OVERFLOW;
                    rsp_zero_d = ALU_ZERO;
                    rsp_cout_d = ALU_COUT;
                    rsp_err_d  = 1'b0;
                end else begin
                    rsp_data_d = 8'h00;
                    rsp_ovf_d  = 1'b0;
                    rsp_zero_d = 1'b0;
                    rsp_cout_d = 1'b0;
                    rsp_err_d  = 1'b1;
                end
                alu_a_d   = 4'b0;
                alu_b_d   = 4'b0;
                alu_ctl_d = 4'b0;
                state_d   = S_RESP;
            end

`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
                // One shift-add step per cycle; the next step's operands are
                // registered from the updated product so they stay stable.
                p_d   = p_next;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = p_next[7:0];
                    rsp_zero_d  = (p_next[7:0] == 8'h00);
                    rsp_ovf_d   = 1'b0;
                    rsp_cout_d  = 1'b0;
                    rsp_err_d   = 1'b0;
                    alu_a_d     = 4'b0;
                    alu_b_d     = 4'b0;
                    alu_ctl_d   = 4'b0;
                    cnt_d       = 2'd0;
                    state_d     = S_RESP;
                end else begin
                    alu_a_d = p_next[7:4];
                    alu_b_d = p_next[0] ? b_q : 4'b0;
                end
            end
`endif

            S_RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = 8'h00;
                    rsp_ovf_d   = 1'b0;
                    rsp_zero_d  = 1'b0;
                    rsp_cout_d  = 1'b0;
                    rsp_err_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            op_q        <= 3'd0;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            alu_a_q     <= 4'd0;
            alu_b_q     <= 4'd0;
            alu_ctl_q   <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_ovf_q   <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_cout_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            p_q         <= 9'd0;
            cnt_q       <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctl_q   <= alu_ctl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_err_q   <= rsp_err_d;
`ifdef ALU_SEQ_MUL_EN
            p_q         <= p_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign CMD_READY    = cmd_ready_q;
    assign ALU_A        = alu_a_q;
    assign ALU_B        = alu_b_q;
    assign ALU_AINV     = alu_ctl_q[3];
    assign ALU_BNEG     = alu_ctl_q[2];
    assign ALU_OPR      = alu_ctl_q[1:0];
    assign RSP_VALID    = rsp_valid_q;
    assign RSP_DATA     = rsp_data_q;
    assign RSP_OVERFLOW = rsp_ovf_q;
    assign RSP_ZERO     = rsp_zero_q;
    assign RSP_COUT     = rsp_cout_q;
    assign RSP_ERR      = rsp_err_q;
    assign DBG_STATE    = state_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural 4-bit ALU, arithmetic reference model, randomized commands.
// Builds with or without ALU_SEQ_MUL_EN; opcode 6 expectations follow the macro.

module tb_alu_cmd_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [2:0] CMD_OP;
    logic [3:0] CMD_A;
    logic [3:0] CMD_B;
    logic [3:0] ALU_A;
    logic [3:0] ALU_B;
    logic       ALU_AINV;
    logic       ALU_BNEG;
    logic [1:0] ALU_OPR;
    logic [3:0] ALU_RESULT;
    logic       ALU_OVERFLOW;
    logic       ALU_ZERO;
    logic       ALU_COUT;
    logic       RSP_VALID;
    logic       RSP_READY;
    logic [7:0] RSP_DATA;
    logic       RSP_OVERFLOW;
    logic       RSP_ZERO;
    logic       RSP_COUT;
    logic       RSP_ERR;
    logic [2:0] DBG_STATE;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected responses packed as {err, cout, zero, ovf, data[7:0]}.
    logic [11:0] exp_q[$];

    alu_cmd_sequencer dut (
        .CLK(CLK), .RESET(RESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_A(CMD_A), .CMD_B(CMD_B),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_AINV(ALU_AINV),
        .ALU_BNEG(ALU_BNEG), .ALU_OPR(ALU_OPR),
        .ALU_RESULT(ALU_RESULT), .ALU_OVERFLOW(ALU_OVERFLOW),
        .ALU_ZERO(ALU_ZERO), .ALU_COUT(ALU_COUT),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_DATA(RSP_DATA), .RSP_OVERFLOW(RSP_OVERFLOW),
        .RSP_ZERO(RSP_ZERO), .RSP_COUT(RSP_COUT), .RSP_ERR(RSP_ERR),
        .DBG_STATE(DBG_STATE)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Combinational 4-bit ALU: optional A/B inversion, BNEG also feeds carry-in.
    logic [3:0] m_a_eff, m_b_eff;
    logic [4:0] m_sum;
    logic       m_ovf;
    always_comb begin
        m_a_eff = ALU_AINV ? ~ALU_A : ALU_A;
        m_b_eff = ALU_BNEG ? ~ALU_B : ALU_B;
        m_sum   = {1'b0, m_a_eff} + {1'b0, m_b_eff} + {4'b0, ALU_BNEG};
        m_ovf   = (m_a_eff[3] == m_b_eff[3]) && (m_sum[3] != m_a_eff[3]);
        case (ALU_OPR)
            2'b00:   ALU_RESULT = m_a_eff & m_b_eff;
            2'b01:   ALU_RESULT = m_a_eff | m_b_eff;
            2'b10:   ALU_RESULT = m_sum[3:0];
            default: ALU_RESULT = {3'b000, m_sum[3] ^ m_ovf};
        endcase
        ALU_OVERFLOW = ALU_OPR[1] & m_ovf;
        ALU_COUT     = ALU_OPR[1] & m_sum[4];
        ALU_ZERO     = (ALU_RESULT == 4'b0);
    end

    // Reference response from plain integer arithmetic.
    function automatic logic [11:0] ref_rsp(input int op, input int a, input int b);
        int sa, sb, s, d;
        logic e, c, v;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        e = 1'b0; c = 1'b0; v = 1'b0; d = 0; s = 0;
        case (op)
            0: d = a & b;
            1: d = a | b;
            5: d = 15 - (a | b);
            2: begin
                s = sa + sb; d = (a + b) % 16; c = (a + b) >= 16; v = (s > 7) || (s < -8);
            end
            3: begin
                s = sa - sb; d = (a - b + 16) % 16; c = (a >= b); v = (s > 7) || (s < -8);
            end
            4: begin
                s = sa - sb; d = (sa < sb) ? 1 : 0; c = (a >= b); v = (s > 7) || (s < -8);
            end
`ifdef ALU_SEQ_MUL_EN
            6: d = a * b;
`endif
            default: e = 1'b1;
        endcase
        return {e, c, (!e && d == 0), v, d[7:0]};
    endfunction

    function automatic int exp_lat(input int op);
`ifdef ALU_SEQ_MUL_EN
        return (op == 6) ? 5 : 2;
`else
        return (op >= 0) ? 2 : 2;
`endif
    endfunction

    function automatic logic [3:0] exp_ctl(input int op);
        logic [3:0] t [0:5];
        t = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
        return t[op];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [25:0] all_outputs();
        return {CMD_READY, RSP_VALID, RSP_DATA, RSP_OVERFLOW, RSP_ZERO, RSP_COUT,
                RSP_ERR, ALU_A, ALU_B, ALU_AINV, ALU_BNEG, ALU_OPR};
    endfunction

    // Driver: wait for READY, issue one command, track latency, check and retire response.
    task automatic run_cmd(input int op, input int a, input int b, input int hold);
        int guard;
        int lat;
        logic [11:0] exp;
        logic [11:0] got;
        @(negedge CLK);
        guard = 0;
        while (!CMD_READY && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        check_eq("cmd_ready_wait", {31'b0, CMD_READY}, 32'd1);
        if (!CMD_READY) return;
        CMD_VALID = 1'b1;
        CMD_OP    = op[2:0];
        CMD_A     = a[3:0];
        CMD_B     = b[3:0];
        exp_q.push_back(ref_rsp(op, a, b));
        exp = ref_rsp(op, a, b);
        @(posedge CLK);
        lat = 0;
        while (lat < 20) begin
            @(negedge CLK);
            if (lat == 0) begin
                CMD_VALID = 1'b0;
                check_eq("ready_drop", {31'b0, CMD_READY}, 32'd0);
            end
            if (lat == 1) begin
                if (exp[11])
                    check_eq("alu_idle_err", {ALU_A, ALU_B, ALU_AINV, ALU_BNEG, ALU_OPR}, 0);
                else if (op <= 5) begin
                    check_eq("alu_ctl", {ALU_AINV, ALU_BNEG, ALU_OPR}, exp_ctl(op));
                    check_eq("alu_ops", {ALU_A, ALU_B}, {a[3:0], b[3:0]});
                end else
                    check_eq("alu_mul_ctl", {ALU_A, ALU_AINV, ALU_BNEG, ALU_OPR}, 8'b0000_0010);
            end
            if (RSP_VALID) break;
            lat++;
        end
        check_eq("rsp_latency", lat, exp_lat(op));
        exp = exp_q.pop_front();
        if (!RSP_VALID) return;
        got = {RSP_ERR, RSP_COUT, RSP_ZERO, RSP_OVERFLOW, RSP_DATA};
        check_eq($sformatf("rsp op=%0d a=%0d b=%0d", op, a, b), got, exp);
        check_eq("alu_idle_resp", {ALU_A, ALU_B, ALU_AINV, ALU_BNEG, ALU_OPR}, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            check_eq("hold_rsp", {RSP_VALID, RSP_ERR, RSP_COUT, RSP_ZERO, RSP_OVERFLOW, RSP_DATA},
                     {1'b1, exp});
            check_eq("hold_ready", {31'b0, CMD_READY}, 32'd0);
        end
        RSP_READY = 1'b1;
        @(negedge CLK);
        RSP_READY = 1'b0;
        check_eq("post_handshake", {RSP_VALID, CMD_READY}, 2'b01);
    endtask

    // Issue a command, then pulse RESET k negedges after the accept edge.
    task automatic reset_mid(input int op, input int a, input int b, input int k);
        int guard;
        @(negedge CLK);
        guard = 0;
        while (!CMD_READY && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        check_eq("rst_ready_wait", {31'b0, CMD_READY}, 32'd1);
        CMD_VALID = 1'b1;
        CMD_OP    = op[2:0];
        CMD_A     = a[3:0];
        CMD_B     = b[3:0];
        @(posedge CLK);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        repeat (k - 1) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check_eq("mid_reset_outputs", all_outputs(), 0);
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check_eq("no_rsp_after_reset", {31'b0, RSP_VALID}, 32'd0);
        end
        check_eq("ready_after_reset", {31'b0, CMD_READY}, 32'd1);
    endtask

    initial begin
        RESET     = 1'b1;
        CMD_VALID = 1'b0;
        CMD_OP    = 3'd0;
        CMD_A     = 4'd0;
        CMD_B     = 4'd0;
        RSP_READY = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_eq("reset_outputs", all_outputs(), 0);
        RESET = 1'b0;
        @(negedge CLK);
        check_eq("ready_after_init", {31'b0, CMD_READY}, 32'd1);

        run_cmd(2, 7, 1, 0);
        run_cmd(3, 5, 5, 0);
        run_cmd(4, 3, 5, 0);
        run_cmd(5, 10, 5, 0);
        run_cmd(1, 10, 5, 0);
        run_cmd(0, 12, 10, 1);
        run_cmd(6, 15, 15, 0);
        run_cmd(6, 0, 9, 0);
        run_cmd(7, 3, 3, 0);
        run_cmd(2, 9, 9, 10);

`ifdef ALU_SEQ_MUL_EN
        reset_mid(6, 13, 11, 3);
`else
        reset_mid(2, 6, 3, 2);
`endif
        run_cmd(2, 2, 2, 0);

        repeat (60) begin
            run_cmd($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 3));
        end

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
